// File: rtl/pr_stream_ctrl.sv
// Partial-reconfiguration stream controller: buffers a length-checked bitstream
// from DMA through a small FIFO toward the ICAP stage, flagging framing errors.
module pr_stream_ctrl #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] word_count,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    input  logic        S_AXIS_TLAST,
    output logic        S_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err,
    output logic        sync_seen
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0] SYNC_WORD = 32'hAA995566;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic [31:0]   in_rem, out_rem, in_rem_nxt, out_rem_nxt;
    logic          push, pop, full, early_last, missing_last;

    assign full          = (count == DEPTH_W);
    assign S_AXIS_TREADY = (state == RUN) && !full && (in_rem != 32'd0);
    assign M_AXIS_TVALID = (state != IDLE) && (count != '0);
    assign M_AXIS_TLAST  = M_AXIS_TVALID && (out_rem == 32'd1);
    assign M_AXIS_TDATA  = mem[rd_ptr];
    assign busy          = (state != IDLE);

    assign push = S_AXIS_TVALID && S_AXIS_TREADY;
    assign pop  = M_AXIS_TVALID && M_AXIS_TREADY;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Early TLAST truncates the transfer: only what is buffered still goes out.
    always_comb begin
        in_rem_nxt   = in_rem;
        out_rem_nxt  = out_rem;
        early_last   = 1'b0;
        missing_last = 1'b0;
        if (pop && out_rem != 32'd0)
            out_rem_nxt = out_rem - 32'd1;
        if (push) begin
            if (S_AXIS_TLAST && in_rem > 32'd1) begin
                early_last  = 1'b1;
                in_rem_nxt  = 32'd0;
                out_rem_nxt = 32'(count_nxt);
            end else begin
                in_rem_nxt   = in_rem - 32'd1;
                missing_last = (in_rem == 32'd1) && !S_AXIS_TLAST;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (push)
            mem[wr_ptr] <= S_AXIS_TDATA;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_rem    <= 32'd0;
            out_rem   <= 32'd0;
            done      <= 1'b0;
            err       <= 3'b000;
            sync_seen <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != 32'd0) begin
                            in_rem    <= word_count;
                            out_rem   <= word_count;
                            err       <= 3'b000;
                            sync_seen <= 1'b0;
                            state     <= RUN;
                        end else begin
                            err[2] <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (abort) begin
                        wr_ptr  <= '0;
                        rd_ptr  <= '0;
                        count   <= '0;
                        in_rem  <= 32'd0;
                        out_rem <= 32'd0;
                        err[2]  <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        if (push)
                            wr_ptr <= wr_ptr + AW'(1);
                        if (pop)
                            rd_ptr <= rd_ptr + AW'(1);
                        count   <= count_nxt;
                        in_rem  <= in_rem_nxt;
                        out_rem <= out_rem_nxt;
                        err[0]  <= err[0] | early_last;
                        err[1]  <= err[1] | missing_last;
                        if (push && S_AXIS_TDATA == SYNC_WORD)
                            sync_seen <= 1'b1;
                        if (out_rem_nxt == 32'd0) begin
                            state <= IDLE;
                            done  <= !(err[0] | early_last) && !(err[1] | missing_last);
                        end else if (in_rem_nxt == 32'd0) begin
                            state <= DRAIN;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pr_stream_ctrl.sv
// Directed plus randomized bench for pr_stream_ctrl; a transfer-level model
// predicts which words come out, where TLAST lands and the final flags.
module tb_pr_stream_ctrl;
    localparam int DEPTH = 16;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        start, abort;
    logic [31:0] word_count;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
    logic        busy, done, sync_seen;
    logic [2:0]  err;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] src_data [64];

    always #5 ACLK = ~ACLK;

    pr_stream_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .abort(abort),
        .word_count(word_count),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
        .busy(busy), .done(done), .err(err), .sync_seen(sync_seen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random(input int n, input int sync_idx);
        for (int i = 0; i < 64; i++)
            src_data[i] = (i < n) ? $urandom : 32'd0;
        if (sync_idx >= 0)
            src_data[sync_idx] = 32'hAA995566;
    endtask

    // tl_pos: 1-based index of the source word carrying TLAST (0 = none).
    task automatic run_xfer(input int wc, input int tl_pos, input int src_len,
                            input int vpct, input int rpct, input int hold,
                            input int abort_after, input bit poke_start);
        int  acc = 0, pops = 0, occ = 0, cyc = 0;
        int  exp_k;
        bit  aborted = 0, do_abort, s_v, m_r, acc_now, pop_now, e0, e1, exp_sync;
        logic [2:0] exp_err;

        exp_k = (tl_pos > 0 && tl_pos < wc) ? tl_pos : wc;
        e0 = (tl_pos > 0 && tl_pos < wc);
        e1 = !e0 && (tl_pos != wc);

        @(negedge ACLK);
        start = 1'b1; word_count = wc;
        @(negedge ACLK);
        start = 1'b0;

        while (pops < exp_k && !aborted && cyc < 4000) begin
            chk("busy", 32'(busy), 32'd1);
            chk("done_mid", 32'(done), 32'd0);
            chk("s_tready", 32'(S_AXIS_TREADY), 32'(acc < exp_k && occ < DEPTH));
            chk("m_tvalid", 32'(M_AXIS_TVALID), 32'(occ > 0));
            if (hold >= 20 && vpct == 100 && cyc == hold)
                chk("fill_stall", acc, DEPTH);

            do_abort = (abort_after > 0) && (acc == abort_after);
            s_v = !do_abort && (acc < src_len) && ($urandom_range(99) < vpct);
            m_r = !do_abort && (cyc >= hold) && ($urandom_range(99) < rpct);
            S_AXIS_TVALID = s_v;
            S_AXIS_TDATA  = (acc < src_len) ? src_data[acc] : 32'd0;
            S_AXIS_TLAST  = (acc + 1 == tl_pos);
            M_AXIS_TREADY = m_r;
            abort         = do_abort;
            start         = poke_start && (cyc == 2);
            word_count    = (poke_start && cyc == 2) ? 32'd1 : wc;

            acc_now = s_v && S_AXIS_TREADY;
            pop_now = m_r && M_AXIS_TVALID;
            if (pop_now) begin
                chk("m_tdata", M_AXIS_TDATA, src_data[pops]);
                chk("m_tlast", 32'(M_AXIS_TLAST), 32'(pops + 1 == exp_k));
                pops++;
            end
            if (acc_now)
                acc++;
            occ = occ + int'(acc_now) - int'(pop_now);

            @(negedge ACLK);
            cyc++;
            if (do_abort) begin
                aborted = 1;
                occ = 0;
            end
        end
        S_AXIS_TVALID = 1'b0; M_AXIS_TREADY = 1'b0; abort = 1'b0; start = 1'b0;

        if (cyc >= 4000)
            chk("timeout_pops", pops, exp_k);

        exp_sync = 0;
        for (int i = 0; i < acc; i++)
            if (src_data[i] == 32'hAA995566) exp_sync = 1;
        exp_err = aborted ? 3'b100 : {1'b0, e1, e0};

        chk("end_busy", 32'(busy), 32'd0);
        chk("end_m_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        chk("end_s_tready", 32'(S_AXIS_TREADY), 32'd0);
        chk("end_done", 32'(done), 32'(!aborted && !e0 && !e1));
        chk("end_err", 32'(err), 32'(exp_err));
        chk("end_sync", 32'(sync_seen), 32'(exp_sync));
        @(negedge ACLK);
        chk("done_pulse_end", 32'(done), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_tready"}, 32'(S_AXIS_TREADY), 32'd0);
        chk({tag, "_m_tvalid"}, 32'(M_AXIS_TVALID), 32'd0);
        chk({tag, "_m_tlast"}, 32'(M_AXIS_TLAST), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_sync"}, 32'(sync_seen), 32'd0);
    endtask

    task automatic load_basic();
        fill_random(0, -1);
        src_data[0] = 32'hFFFFFFFF;
        src_data[1] = 32'hAA995566;
        src_data[2] = 32'h20000000;
        src_data[3] = 32'h30008001;
    endtask

    initial begin
        int wc, tl, r;
        ARESETN = 1'b0; start = 1'b0; abort = 1'b0; word_count = 32'd0;
        S_AXIS_TDATA = 32'd0; S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
        M_AXIS_TREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        chk_reset_vals("reset");
        ARESETN = 1'b1;
        @(negedge ACLK);

        // basic 4-word stream containing the sync word
        load_basic();
        run_xfer(4, 4, 4, 100, 100, 0, 0, 0);

        // zero-length start
        @(negedge ACLK);
        start = 1'b1; word_count = 32'd0;
        @(negedge ACLK);
        start = 1'b0;
        chk("zero_err", 32'(err), 32'd4);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_done", 32'(done), 32'd0);
        @(negedge ACLK);
        chk("zero_busy2", 32'(busy), 32'd0);
        chk("zero_done2", 32'(done), 32'd0);

        // backpressure: fill the FIFO, stall 30 cycles, restart attempt ignored
        fill_random(40, 7);
        run_xfer(40, 40, 40, 100, 100, 30, 0, 1);

        // early TLAST on word 5 of 8
        fill_random(8, -1);
        run_xfer(8, 5, 8, 70, 70, 0, 0, 0);

        // missing TLAST
        fill_random(3, -1);
        run_xfer(3, 0, 3, 100, 100, 0, 0, 0);

        // abort after 6 of 20 with the sink stalled so the FIFO holds data
        fill_random(20, -1);
        run_xfer(20, 20, 20, 100, 0, 0, 6, 0);

        for (int t = 0; t < 8; t++) begin
            wc = $urandom_range(1, 30);
            r  = $urandom_range(2);
            tl = (r == 0) ? wc : (r == 1) ? $urandom_range(1, wc + 2) : 0;
            fill_random(wc + 2, ($urandom_range(1) == 1) ? $urandom_range(0, wc - 1) : -1);
            run_xfer(wc, tl, wc + 2, $urandom_range(30, 100), $urandom_range(30, 100), 0, 0, 0);
        end

        // reset in the middle of a transfer, then a clean transfer afterwards
        fill_random(20, -1);
        @(negedge ACLK);
        start = 1'b1; word_count = 32'd20;
        @(negedge ACLK);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = src_data[i]; S_AXIS_TLAST = 1'b0;
            @(negedge ACLK);
        end
        S_AXIS_TVALID = 1'b0;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        ARESETN = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("post_reset_busy", 32'(busy), 32'd0);
        load_basic();
        run_xfer(4, 4, 4, 100, 100, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
